control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit bus-based CPU.
- Sequences fetch (T0–T2) and execute (T3–T6) steps for each instruction. Each step drives the one-cycle enable/out strobes the datapath consumes: register enables, bus drivers, ALU op_code, PC increment and MDR read.
- Replaces the hand-timed stimulus currently used to exercise the datapath. Sits beside the datapath and reads the IR contents back from it.

Parameters:
OPW, 5, opcode width (ir[31:27])
NREG, 16, number of general registers; width of the one-hot select buses

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
ir  in  32  current IR contents from datapath
stop  in  1  hold before next fetch while high
reg_in  out  16  one-hot general register enable (Rn_enable)
reg_out  out  16  one-hot general register bus driver (Rnout)
pc_in, pc_out, pc_inc  out  1 each  PC enable / bus drive / increment
mar_in, mdr_in, mdr_out, mdr_read  out  1 each  memory interface strobes
ir_in, y_in, c_out  out  1 each  IR enable, Y enable, sign-extended C onto bus
zlo_in, zhi_in, zlo_out, zhi_out  out  1 each  Z register halves
hi_in, lo_in  out  1 each  HI/LO enables
op_code  out  5  ALU operation
running  out  1  high while sequencing (not IDLE/HALTED)
illegal  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Clocking and reset: one clock domain (clk). reset is synchronous and active-high.
- Outputs are a combinational function of the registered state and ir.
  - Every strobe is high for exactly one full cycle.
  - Strobes not listed for a state are 0; op_code defaults to 0.
- Reset:
  - On the clock edge where reset=1, state goes to IDLE.
  - In IDLE all outputs are 0, including running and illegal.
  - Reset mid-instruction abandons the instruction immediately.
- IR fields: opc=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15]. reg_in/reg_out = 1<<field.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED.
- IDLE: go to T0 when stop=0, else stay. stop is sampled only in IDLE.
- Fetch:
  - T0: pc_out, mar_in, pc_inc, zlo_in.
  - T1: zlo_out, pc_in, mdr_read, mdr_in.
  - T2: mdr_out, ir_in.
- Decode uses ir in T3 (IR was written at the end of T2).
- R-ALU (opc 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol):
  - T3: reg_out[Rb], y_in.
  - T4: reg_out[Rc], op_code=opc, zlo_in.
  - T5: zlo_out, reg_in[Ra].
  - Then IDLE.
- Immediate (01100 addi, 01101 andi, 01110 ori):
  - Same as R-ALU except T4 uses c_out instead of reg_out[Rc].
  - op_code = 00011 / 00101 / 00110 respectively.
- mul (01111), div (10000):
  - T3: reg_out[Ra], y_in.
  - T4: reg_out[Rb], op_code=opc, zlo_in, zhi_in.
  - T5: zlo_out, lo_in.
  - T6: zhi_out, hi_in.
  - Then IDLE.
- Unary (10001 neg, 10010 not):
  - T3: reg_out[Rb], op_code=opc, zlo_in.
  - T4: zlo_out, reg_in[Ra].
  - Then IDLE.
- nop (11010): T3 with no strobes, then IDLE.
- halt (11011): T3 with no strobes, then HALTED. HALTED is sticky, all outputs 0, exited only by reset.
- Any other opc: T3 pulses illegal=1, no other strobes, then IDLE. Treated as nop.
- Instruction lengths, counted from T0 to the last execute state: R-ALU/imm 6 cycles, mul/div 7, unary 5, nop/illegal 4.
- running: 1 in T0..T6, 0 in IDLE and HALTED. IDLE lasts at least one cycle between instructions.
- Ra=Rb (e.g. add r3,r3,r3) is legal and needs no special handling.
- At most one reg_in bit and at most one bus driver are high in any cycle.

Test Plan:
- Reset behaviour: hold reset 2 cycles with stop=1 -> all outputs 0, state stays IDLE. Drop stop -> T0 next cycle with pc_out=mar_in=pc_inc=zlo_in=1.
- sub: ir=0x20228000 (sub r0,r4,r5) -> T3 reg_out=0x0010 with y_in; T4 reg_out=0x0020, op_code=00100, zlo_in; T5 zlo_out, reg_in=0x0001. running high for 6 cycles, then IDLE.
- addi: ir=0x611FFFFB (addi r2,r3,-5) -> T3 reg_out=0x0008; T4 c_out=1, op_code=00011; T5 reg_in=0x0004.
- mul: ir=0x7B380000 (mul r6,r7) -> T4 op_code=01111 with zlo_in and zhi_in both high; T5 lo_in; T6 zhi_out with hi_in; 7-cycle instruction.
- halt and reset recovery: ir=0xD8000000 -> HALTED after T3, outputs 0 for 20 cycles regardless of stop. reset -> IDLE; reset asserted during T4 of a sub -> next cycle IDLE, zlo_in=0, no reg_in pulse.
- illegal and nop: ir=0xF8000000 -> illegal=1 for exactly the T3 cycle, no reg_in, then T0 after one IDLE cycle. ir=0xD0000000 -> 4-cycle nop with no strobes in T3.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the 32-bit bus CPU.
// Steps fetch T0-T2 and execute T3-T6, decoding the IR read back from the datapath.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ir,
  input  logic            stop,
  output logic [NREG-1:0] reg_in,
  output logic [NREG-1:0] reg_out,
  output logic            pc_in,
  output logic            pc_out,
  output logic            pc_inc,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            mdr_read,
  output logic            ir_in,
  output logic            y_in,
  output logic            c_out,
  output logic            zlo_in,
  output logic            zhi_in,
  output logic            zlo_out,
  output logic            zhi_out,
  output logic            hi_in,
  output logic            lo_in,
  output logic [OPW-1:0]  op_code,
  output logic            running,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALTED
  } state_e;

  typedef enum logic [2:0] {
    C_RALU,
    C_IMM,
    C_MD,
    C_UN,
    C_NOP,
    C_HALT,
    C_ILL
  } cls_e;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  state_e state_q, state_d;
  cls_e   cls;

  logic [OPW-1:0] opc;
  logic [3:0]     ra, rb, rc;
  logic [OPW-1:0] imm_op;
  logic [NREG-1:0] sel_a, sel_b, sel_c;
  logic           is_ralu, is_imm, is_md;
  logic           is_un, is_nop, is_halt;
  logic           unused_ir;

  assign opc = ir[31:32-OPW];
  assign ra  = ir[26:23];
  assign rb  = ir[22:19];
  assign rc  = ir[18:15];

  assign unused_ir = ^ir[14:0];

  assign sel_a = NREG'(1) << ra;
  assign sel_b = NREG'(1) << rb;
  assign sel_c = NREG'(1) << rc;

  assign is_ralu = (opc >= OP_ADD) && (opc <= OP_ROL);
  assign is_imm  = (opc >= OP_ADDI) && (opc <= OP_ORI);
  assign is_md   = (opc == OP_MUL) || (opc == OP_DIV);
  assign is_un   = (opc == OP_NEG) || (opc == OP_NOT);
  assign is_nop  = (opc == OP_NOP);
  assign is_halt = (opc == OP_HALT);

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      is_ralu: cls = C_RALU;
      is_imm:  cls = C_IMM;
      is_md:   cls = C_MD;
      is_un:   cls = C_UN;
      is_nop:  cls = C_NOP;
      is_halt: cls = C_HALT;
      default: cls = C_ILL;
    endcase
  end

  // Immediate forms reuse the ALU codes of their register twins.
  always_comb begin
    imm_op = opc;
    unique case (opc)
      OP_ADDI: imm_op = OP_ADD;
      OP_ANDI: imm_op = OP_AND;
      OP_ORI:  imm_op = OP_OR;
      default: imm_op = opc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!stop) state_d = S_T0;
      end
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        unique case (cls)
          C_RALU, C_IMM,
          C_MD, C_UN: state_d = S_T4;
          C_HALT:     state_d = S_HALTED;
          default:    state_d = S_IDLE;
        endcase
      end
      S_T4: begin
        if (cls == C_UN) state_d = S_IDLE;
        else             state_d = S_T5;
      end
      S_T5: begin
        if (cls == C_MD) state_d = S_T6;
        else             state_d = S_IDLE;
      end
      S_T6:     state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_in   = '0;
    reg_out  = '0;
    pc_in    = 1'b0;
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    mdr_read = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    zlo_in   = 1'b0;
    zhi_in   = 1'b0;
    zlo_out  = 1'b0;
    zhi_out  = 1'b0;
    hi_in    = 1'b0;
    lo_in    = 1'b0;
    op_code  = '0;
    running  = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_T0: begin
        running = 1'b1;
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        pc_inc  = 1'b1;
        zlo_in  = 1'b1;
      end
      S_T1: begin
        running  = 1'b1;
        zlo_out  = 1'b1;
        pc_in    = 1'b1;
        mdr_read = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        running = 1'b1;
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        running = 1'b1;
        unique case (cls)
          C_RALU, C_IMM: begin
            reg_out = sel_b;
            y_in    = 1'b1;
          end
          C_MD: begin
            reg_out = sel_a;
            y_in    = 1'b1;
          end
          C_UN: begin
            reg_out = sel_b;
            op_code = opc;
            zlo_in  = 1'b1;
          end
          C_ILL:   illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        running = 1'b1;
        unique case (cls)
          C_RALU: begin
            reg_out = sel_c;
            op_code = opc;
            zlo_in  = 1'b1;
          end
          C_IMM: begin
            c_out   = 1'b1;
            op_code = imm_op;
            zlo_in  = 1'b1;
          end
          C_MD: begin
            reg_out = sel_b;
            op_code = opc;
            zlo_in  = 1'b1;
            zhi_in  = 1'b1;
          end
          C_UN: begin
            zlo_out = 1'b1;
            reg_in  = sel_a;
          end
          default: ;
        endcase
      end
      S_T5: begin
        running = 1'b1;
        zlo_out = 1'b1;
        if (cls == C_MD) lo_in = 1'b1;
        else             reg_in = sel_a;
      end
      S_T6: begin
        running = 1'b1;
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
